pe_array_feeder: RTL
====================

Name: pe_array_feeder

Overview:
- Upstream-side controller for the PE_array streaming port; drives the array's `data_in` and `rst_in`, then captures its serial `psum_out`.
- Merges a weight stream and an activation stream, each with a valid/ready handshake, into the bubble-free interleaved 27-bit word sequence the array consumes every cycle.
- Each group is O_CH weight words followed by 1 activation word. After a fixed drain, it collects O_CH partial sums.
- Sits between the on-chip weight/activation buffers and PE_array.

Parameters:
- O_CH, 9, PE rows = weight words per group = psum words collected
- ROW_LENGTH, 7, PE row length
- K, 10, runs; total groups = ROW_LENGTH*K
- WIDTH, 14, psum bit width
- DRAIN, 3, cycles from last word driven to first valid psum word

Ports:
- clk_in  in  1  clock, rising edge
- rst_in  in  1  asynchronous active-low reset
- start  in  1  begin a pass; sampled only in IDLE
- w_valid  in  1  weight word valid
- w_ready  out  1  weight word accepted this cycle
- w_data  in  27  weight word
- a_valid  in  1  activation word valid
- a_ready  out  1  activation word accepted this cycle
- a_data  in  27  activation word
- pe_data  out  27  to PE_array `data_in`
- pe_rst_n  out  1  to PE_array `rst_in` (active-low)
- psum_in  in  WIDTH  from PE_array `psum_out`
- res_valid  out  1  res_data holds one captured psum
- res_data  out  WIDTH  captured psum
- res_idx  out  ceil(log2(O_CH))  row index of res_data
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse, coincident with last res_valid
- underrun  out  1  sticky: a required input word was missing

Behaviour:
- Reset: all outputs 0, including pe_rst_n (array held in reset). State goes to IDLE. Asynchronous reset mid-pass aborts immediately; there is no resume.
- TOTAL = (O_CH+1)*ROW_LENGTH*K. slot counter runs 0..O_CH. Group counter runs 0..ROW_LENGTH*K-1.
- States: IDLE -> LOAD -> DRAIN -> COLLECT -> IDLE.
- IDLE:
  - pe_rst_n=0, pe_data=0, w_ready=a_ready=0.
  - start=1 at an edge -> LOAD, clears counters and underrun.
- LOAD lasts exactly TOTAL cycles; it never stalls.
  - Slot < O_CH: w_ready=1, a_ready=0.
  - Slot == O_CH: a_ready=1, w_ready=0.
  - ready is combinational from state/slot and independent of valid.
  - At each edge: pe_data <= selected data if its valid=1; otherwise pe_data <= 0 and underrun <= 1. Then pe_rst_n <= 1 and slot/group advance.
  - So word n appears on pe_data one cycle after its handshake. pe_rst_n rises together with word 0.
  - After the edge that registers word TOTAL-1 -> DRAIN.
- DRAIN:
  - pe_data holds the last word, pe_rst_n=1.
  - Last word is visible in DRAIN cycle 0.
  - After DRAIN cycles -> COLLECT.
- COLLECT lasts O_CH cycles (j = 0..O_CH-1):
  - At each edge: res_data <= psum_in, res_idx <= j, res_valid <= 1.
  - psum word j is sampled in cycle L+DRAIN+j, where L is the first cycle the last word is visible.
  - done <= 1 with j=O_CH-1.
  - Next state IDLE: res_valid, done, pe_rst_n return to 0; pe_data <= 0.
- start outside IDLE is ignored. start in the IDLE cycle directly after COLLECT is honoured (back-to-back passes).
- underrun holds until the next accepted start or reset. Zero-substituted words still count toward TOTAL.

Optional Feature:
- Macro: PE_FEEDER_UNDERRUN_HOLD_EN.
- Defined: on underrun, pe_data repeats its previous value instead of 0. underrun is still set.
- Undefined: a zero word is substituted on underrun.

Test Plan:
- O_CH=2, ROW_LENGTH=1, K=2 (TOTAL=6), inputs always valid, w=1,2,3,4, a=0xA,0xB -> pe_data sequence 1,2,0xA,3,4,0xB on consecutive cycles. pe_rst_n rises with word 1; busy throughout; underrun=0.
- Same run, psum_in driven 0x11 then 0x22 at DRAIN=3 alignment -> res_valid two cycles, res_data 0x11/0x22, res_idx 0/1; done pulses with idx 1; busy then returns to 0.
- a_valid=0 in the slot of the first activation -> pe_data word 3 = 0 (with PE_FEEDER_UNDERRUN_HOLD_EN: 2); underrun=1 sticky; TOTAL unchanged.
- start pulsed during LOAD and COLLECT -> no effect. start in the first IDLE cycle after done -> second pass starts and underrun clears.
- rst_in low mid-LOAD -> all outputs 0 asynchronously, pe_rst_n=0. After release, state is IDLE and idle until start.
- Default parameters, 700 words, psum_in counting -> exactly 9 res words, idx 0..8, sampled 3 cycles after the last word.

Source files
------------

// File: rtl/pe_array_feeder.sv
// pe_array_feeder: merges weight/activation streams into the PE_array data_in sequence, then captures O_CH psums.
// Optional macro PE_FEEDER_UNDERRUN_HOLD_EN: on underrun repeat the previous pe_data word instead of a zero word.
module pe_array_feeder #(
  parameter int O_CH       = 9,
  parameter int ROW_LENGTH = 7,
  parameter int K          = 10,
  parameter int WIDTH      = 14,
  parameter int DRAIN      = 3,
  localparam int IDX_W     = (O_CH > 1) ? $clog2(O_CH) : 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start,
  input  logic             w_valid,
  output logic             w_ready,
  input  logic [26:0]      w_data,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [26:0]      a_data,
  output logic [26:0]      pe_data,
  output logic             pe_rst_n,
  input  logic [WIDTH-1:0] psum_in,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic [IDX_W-1:0] res_idx,
  output logic             busy,
  output logic             done,
  output logic             underrun
);

  localparam int GROUPS = ROW_LENGTH * K;
  localparam int SLOT_W = $clog2(O_CH + 1);
  localparam int GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int DRN_W  = (DRAIN > 1) ? $clog2(DRAIN) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_COLLECT = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [SLOT_W-1:0]  slot_r;
  logic [GRP_W-1:0]   group_r;
  logic [DRN_W-1:0]   drain_r;
  logic               last_slot_s;
  logic               last_group_s;
  logic               last_drain_s;
  logic               last_res_s;
  logic               sel_valid_s;
  logic [26:0]        sel_data_s;
  logic [26:0]        fill_data_s;

  assign last_slot_s  = (slot_r == SLOT_W'(O_CH));
  assign last_group_s = (group_r == GRP_W'(GROUPS - 1));
  assign last_drain_s = (drain_r == DRN_W'(DRAIN - 1));
  assign last_res_s   = (slot_r == SLOT_W'(O_CH - 1));
  assign sel_valid_s  = last_slot_s ? a_valid : w_valid;
  assign sel_data_s   = last_slot_s ? a_data : w_data;
  assign busy         = (state_r != ST_IDLE);

`ifdef PE_FEEDER_UNDERRUN_HOLD_EN
  assign fill_data_s = pe_data;
`else
  assign fill_data_s = 27'd0;
`endif

  // State register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and ready decode; ready depends only on state and slot, never on valid
  always_comb begin
    state_s = state_r;
    w_ready = 1'b0;
    a_ready = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_LOAD;
        else       state_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (last_slot_s) a_ready = 1'b1;
        else             w_ready = 1'b1;
        if (last_slot_s && last_group_s) state_s = (DRAIN == 0) ? ST_COLLECT : ST_DRAIN;
        else                             state_s = ST_LOAD;
      end
      ST_DRAIN: begin
        if (last_drain_s) state_s = ST_COLLECT;
        else              state_s = ST_DRAIN;
      end
      ST_COLLECT: begin
        if (last_res_s) state_s = ST_IDLE;
        else            state_s = ST_COLLECT;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Datapath: slot doubles as the psum row index during COLLECT
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      slot_r    <= {SLOT_W{1'b0}};
      group_r   <= {GRP_W{1'b0}};
      drain_r   <= {DRN_W{1'b0}};
      pe_data   <= 27'd0;
      pe_rst_n  <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= {WIDTH{1'b0}};
      res_idx   <= {IDX_W{1'b0}};
      done      <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          pe_data   <= 27'd0;
          pe_rst_n  <= 1'b0;
          res_valid <= 1'b0;
          done      <= 1'b0;
          if (start) begin
            slot_r   <= {SLOT_W{1'b0}};
            group_r  <= {GRP_W{1'b0}};
            drain_r  <= {DRN_W{1'b0}};
            underrun <= 1'b0;
          end
        end
        ST_LOAD: begin
          res_valid <= 1'b0;
          done      <= 1'b0;
          pe_rst_n  <= 1'b1;
          drain_r   <= {DRN_W{1'b0}};
          if (sel_valid_s) begin
            pe_data <= sel_data_s;
          end else begin
            pe_data  <= fill_data_s;
            underrun <= 1'b1;
          end
          if (last_slot_s) begin
            slot_r <= {SLOT_W{1'b0}};
            if (last_group_s) group_r <= {GRP_W{1'b0}};
            else              group_r <= group_r + GRP_W'(1);
          end else begin
            slot_r <= slot_r + SLOT_W'(1);
          end
        end
        ST_DRAIN: begin
          drain_r <= drain_r + DRN_W'(1);
        end
        ST_COLLECT: begin
          res_data  <= psum_in;
          res_idx   <= IDX_W'(slot_r);
          res_valid <= 1'b1;
          if (last_res_s) begin
            done     <= 1'b1;
            pe_rst_n <= 1'b0;
            pe_data  <= 27'd0;
            slot_r   <= {SLOT_W{1'b0}};
          end else begin
            done   <= 1'b0;
            slot_r <= slot_r + SLOT_W'(1);
          end
        end
        default: begin
          pe_rst_n  <= 1'b0;
          res_valid <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule
